mac_tile_db: RTL

Double-buffered, dual-mode processing element for the systolic MAC array; successor to the single-weight tile. Supports weight-stationary (WS) operation with a shadow weight register, so the next kernel loads while the current one executes, and output-stationary (OS) operation with a local accumulator and column drain. Activations and instructions flow west→east; psums, weights (OS) and drained results flow north→south.

---
 rtl/mac_tile_pkg.sv | 16 +
 rtl/mac_tile_db_mac_unit.sv | 37 +++
 rtl/mac_tile_db.sv | 113 +++++++++++
 3 files changed

// File: rtl/mac_tile_pkg.sv
// Shared definitions for the double-buffered WS/OS MAC tile.
package mac_tile_pkg;
    localparam int INST_LOAD       = 0;
    localparam int INST_EXEC       = 1;
    localparam int INST_SWAP_DRAIN = 2;

    typedef enum logic {
        MODE_WS = 1'b0,
        MODE_OS = 1'b1
    } mode_t;

    typedef enum logic {
        ARMED = 1'b0,
        HELD  = 1'b1
    } cap_state_t;
endpackage

// File: rtl/mac_tile_db_mac_unit.sv
// Combinational unsigned-activation x signed-weight multiply plus psum add.
// MAC_TILE_SAT_EN selects signed saturation of the add; otherwise it wraps.
module mac_unit #(
    parameter int BW      = 4,
    parameter int PSUM_BW = 16
) (
    input  logic [BW-1:0]      act,
    input  logic [BW-1:0]      weight,
    input  logic [PSUM_BW-1:0] addend,
    output logic [PSUM_BW-1:0] sum
);
    logic [2*BW-1:0]    act_x;
    logic [2*BW-1:0]    wt_x;
    logic [2*BW-1:0]    product;
    logic [PSUM_BW-1:0] product_x;

    assign act_x     = {{BW{1'b0}}, act};
    assign wt_x      = {{BW{weight[BW-1]}}, weight};
    // Low 2*BW bits of the product are exact for unsigned x signed operands.
    assign product   = act_x * wt_x;
    assign product_x = {{(PSUM_BW-2*BW){product[2*BW-1]}}, product};

`ifdef MAC_TILE_SAT_EN
    logic [PSUM_BW:0] wide;

    assign wide = {product_x[PSUM_BW-1], product_x} + {addend[PSUM_BW-1], addend};

    always_comb begin
        if (wide[PSUM_BW] != wide[PSUM_BW-1])
            sum = wide[PSUM_BW] ? {1'b1, {(PSUM_BW-1){1'b0}}} : {1'b0, {(PSUM_BW-1){1'b1}}};
        else
            sum = wide[PSUM_BW-1:0];
    end
`else
    assign sum = product_x + addend;
`endif
endmodule

// File: rtl/mac_tile_db.sv
// Double-buffered systolic PE: weight-stationary with shadow weight, or
// output-stationary with local accumulator and column drain (MAC_TILE_SAT_EN in mac_unit).
//   state | meaning
//   ARMED | next load word is captured into w_shadow
//   HELD  | w_shadow occupied; further loads are forwarded east
module mac_tile_db
    import mac_tile_pkg::*;
#(
    parameter int BW      = 4,
    parameter int PSUM_BW = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mode,
    input  logic [BW-1:0]      in_w,
    input  logic [2:0]         inst_w,
    input  logic [PSUM_BW-1:0] in_n,
    input  logic               valid_n,
    output logic [BW-1:0]      out_e,
    output logic [2:0]         inst_e,
    output logic [PSUM_BW-1:0] out_s,
    output logic               valid_s
);
    mode_t              mode_cur;
    mode_t              mode_q;
    cap_state_t         cap_state;
    logic [BW-1:0]      w_shadow;
    logic [BW-1:0]      w_active;
    logic [PSUM_BW-1:0] acc;
    logic               is_os;
    logic               do_load;
    logic               do_exec;
    logic               do_sd;
    logic [BW-1:0]      mac_wt;
    logic [PSUM_BW-1:0] mac_add;
    logic [PSUM_BW-1:0] mac_sum;

    assign mode_cur = mode_t'(mode);
    assign is_os    = (mode_cur == MODE_OS);
    assign do_load  = inst_w[INST_LOAD];
    assign do_exec  = inst_w[INST_EXEC];
    assign do_sd    = inst_w[INST_SWAP_DRAIN];

    // One multiplier serves both modes: WS adds to the incoming psum, OS to acc.
    assign mac_wt  = is_os ? in_n[BW-1:0] : w_active;
    assign mac_add = is_os ? acc : in_n;

    mac_unit #(
        .BW      (BW),
        .PSUM_BW (PSUM_BW)
    ) u_mac (
        .act    (in_w),
        .weight (mac_wt),
        .addend (mac_add),
        .sum    (mac_sum)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_e     <= '0;
            inst_e    <= '0;
            out_s     <= '0;
            valid_s   <= 1'b0;
            w_active  <= '0;
            w_shadow  <= '0;
            acc       <= '0;
            cap_state <= ARMED;
            mode_q    <= MODE_WS;
        end else begin
            mode_q            <= mode_cur;
            inst_e[2:1]       <= inst_w[2:1];
            inst_e[INST_LOAD] <= 1'b0;
            if (inst_w != 3'b000)
                out_e <= in_w;

            if (!is_os) begin
                if (do_sd)
                    w_active <= w_shadow;
                case (cap_state)
                    ARMED: begin
                        if (do_load) begin
                            w_shadow  <= in_w;
                            cap_state <= HELD;
                        end
                    end
                    HELD: begin
                        if (do_load)
                            inst_e[INST_LOAD] <= 1'b1;
                        if (do_sd)
                            cap_state <= ARMED;
                    end
                    default: cap_state <= ARMED;
                endcase
                out_s   <= do_exec ? mac_sum : '0;
                valid_s <= do_exec;
            end else if (do_sd) begin
                out_s   <= do_exec ? mac_sum : acc;
                valid_s <= 1'b1;
                acc     <= '0;
            end else if (do_exec) begin
                acc     <= mac_sum;
                out_s   <= {{(PSUM_BW-BW){1'b0}}, in_n[BW-1:0]};
                valid_s <= 1'b0;
            end else begin
                out_s   <= in_n;
                valid_s <= valid_n;
            end

            if (mode_cur != mode_q)
                acc <= '0;
        end
    end
endmodule
